mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MA-stage data-memory controller. Sits directly downstream of the EX/MA pipeline register.
//  Converts the registered load/store request into a word-addressed req/ack data-memory
//  transaction, handling byte-lane enables and load sign/zero extension.
//  Stalls the pipeline until the transaction completes, then presents load data to the MA/WB register.
// PARAMETERS
//  NBITS        32   data/address width (byte lanes fixed at 4; only 32 supported)
//  TIMEOUT_CYC  16   max cycles in ACCESS before abort with o_bus_err (>=2)
// PORTS
//  i_clk           in   1      clock, rising edge
//  i_rst_n         in   1      asynchronous active-low reset
//  i_flg_mem_op    in   1      1 = current instr is a memory op (from EX/MA)
//  i_flg_mem_type  in   1      0 = load, 1 = store
//  i_flg_mem_size  in   2      00 byte, 01 half, 10 word, 11 treated as word
//  i_flg_unsign    in   1      1 = zero-extend load, 0 = sign-extend
//  i_eff_addr      in   NBITS  byte address
//  i_store_data    in   NBITS  rt value for stores (LSBs significant)
//  o_stall         out  1      freeze PC/IF/ID/EX and EX/MA register
//  o_load_data     out  NBITS  extended load result, valid while o_done
//  o_done          out  1      one-cycle pulse: access finished (load or store)
//  o_misalign      out  1      one-cycle pulse: misaligned access rejected
//  o_bus_err       out  1      one-cycle pulse: ack timeout, access aborted
//  o_dm_req        out  1      memory request, held until ack
//  o_dm_we         out  1      1 = write
//  o_dm_addr       out  NBITS-2  word address = eff_addr[NBITS-1:2]
//  o_dm_be         out  4      byte enables (bit0 = addr byte 0; little-endian)
//  o_dm_wdata      out  NBITS  lane-replicated store data
//  i_dm_ack        in   1      memory completed current request
//  i_dm_rdata      in   NBITS  read word, valid with i_dm_ack
// BEHAVIOUR
//  Reset (async, any state): state IDLE; all outputs 0; captured regs and timeout counter 0.
//  Reset asserted mid-ACCESS drops o_dm_req immediately; no completion pulse.
//  Alignment: half needs addr[0]==0, word needs addr[1:0]==0; byte always aligned.
//  start = IDLE & i_flg_mem_op & aligned. o_misalign = IDLE & i_flg_mem_op & ~aligned
//    (combinational pulse; no access, no stall).
//  FSM:
//   IDLE   : on start, capture type/size/unsign/addr/store data; cnt<=0; -> ACCESS.
//   ACCESS : o_dm_req=1; addr/we/be/wdata driven from captured regs, stable until ack.
//            i_dm_ack -> capture extended rdata into o_load_data; -> DONE.
//            else cnt==TIMEOUT_CYC-1 -> o_bus_err pulse next cycle; -> IDLE.
//            else cnt++.
//   DONE   : o_done=1 one cycle; EX/MA still holds the finished op, inputs ignored; -> IDLE.
//  o_stall = start | (state==ACCESS). Low in DONE, so the pipeline advances at end of DONE.
//  Timing: ack in first ACCESS cycle gives 2 stall cycles, o_done in the 3rd cycle.
//    Each extra ack wait adds 1 stall cycle.
//  Simultaneous ack and timeout in the same cycle: ack wins.
//  o_load_data holds its value until the next load completes (stores leave it unchanged).
//  Store lanes:
//   byte  -> be = 1<<addr[1:0],          wdata = {4{d[7:0]}}
//   half  -> be = addr[1] ? 1100 : 0011, wdata = {2{d[15:0]}}
//   word  -> be = 1111,                  wdata = d
//  Loads: o_dm_we=0, be as above. Result = rdata >> (8*addr[1:0]), then zero- or
//    sign-extended from 8/16 bits per size/unsign. Word loads are unextended.
// STRUCTURE
//  Package mem_pkg: MEM_SZ_BYTE/HALF/WORD encodings, MEM_LOAD/MEM_STORE, FSM state enum
//    {IDLE, ACCESS, DONE}.
//  Sub-module mem_lane_align (combinational): size, addr[1:0], unsign, store data, rdata
//    -> be, wdata, extended load data, aligned flag.
//  Top: FSM, capture registers, timeout counter, output registers.
// TESTING
//  lw addr 0x100, ack on 1st ACCESS cycle, rdata 0xDEADBEEF -> stall 2 cycles, o_done cycle 3,
//    o_load_data 0xDEADBEEF, be 1111, o_dm_addr 0x40.
//  lb signed addr 0x103, rdata 0x80_00_00_00 -> 0xFFFFFF80; lbu same -> 0x00000080.
//  sh addr 0x102, data 0x1234ABCD, ack after 3 waits -> be 1100, wdata 0xABCDABCD, 5 stall cycles.
//  lw addr 0x101 -> o_misalign pulse, o_dm_req never high, o_stall 0.
//  No ack for TIMEOUT_CYC=16 cycles -> o_bus_err pulse, IDLE, o_done never high.
//  Reset asserted mid-ACCESS -> o_dm_req/o_stall 0 immediately; next lw after release completes.
//  Back-to-back lw/sw: DONE ignores held op, second op starts the cycle after DONE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state and data-memory command payload for the MA-stage
// memory access unit.
package mem_pkg;

  localparam int unsigned MEM_NBITS  = 32;
  localparam int unsigned MEM_NLANES = 4;
  localparam int unsigned MEM_AW     = MEM_NBITS - 2;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b10;

  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_AW-1:0]     addr;
    logic [MEM_NLANES-1:0] be;
    logic [MEM_NBITS-1:0]  wdata;
  } dm_cmd_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication, load shift and extension,
// and the alignment check for a given size and low address bits.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]            i_size,
  input  logic [1:0]            i_addr_lo,
  input  logic                  i_unsign,
  input  logic [MEM_NBITS-1:0]  i_st_data,
  input  logic [MEM_NBITS-1:0]  i_rdata,
  output logic [MEM_NLANES-1:0] o_be_c,
  output logic [MEM_NBITS-1:0]  o_wdata_c,
  output logic [MEM_NBITS-1:0]  o_ld_data_c,
  output logic                  o_aligned_c
);

  logic [MEM_NBITS-1:0] shifted;

  assign shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be_c      = '0;
    o_wdata_c   = '0;
    o_ld_data_c = shifted;
    o_aligned_c = 1'b0;
    case (i_size)
      MEM_SZ_BYTE: begin
        o_be_c      = MEM_NLANES'(1) << i_addr_lo;
        o_wdata_c   = {4{i_st_data[7:0]}};
        o_ld_data_c = {{(MEM_NBITS-8){~i_unsign & shifted[7]}}, shifted[7:0]};
        o_aligned_c = 1'b1;
      end
      MEM_SZ_HALF: begin
        o_be_c      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_c   = {2{i_st_data[15:0]}};
        o_ld_data_c = {{(MEM_NBITS-16){~i_unsign & shifted[15]}}, shifted[15:0]};
        o_aligned_c = ~i_addr_lo[0];
      end
      // word and the reserved 2'b11 encoding
      default: begin
        o_be_c      = 4'b1111;
        o_wdata_c   = i_st_data;
        o_ld_data_c = shifted;
        o_aligned_c = (i_addr_lo == 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MA-stage data-memory controller: turns the EX/MA load/store request into a
// req/ack word-addressed transaction and stalls the pipeline until it ends.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned NBITS       = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flg_mem_op,
  input  logic             i_flg_mem_type,
  input  logic [1:0]       i_flg_mem_size,
  input  logic             i_flg_unsign,
  input  logic [NBITS-1:0] i_eff_addr,
  input  logic [NBITS-1:0] i_store_data,
  output logic             o_stall,
  output logic [NBITS-1:0] o_load_data,
  output logic             o_done,
  output logic             o_misalign,
  output logic             o_bus_err,
  output logic             o_dm_req,
  output logic             o_dm_we,
  output logic [NBITS-3:0] o_dm_addr,
  output logic [3:0]       o_dm_be,
  output logic [NBITS-1:0] o_dm_wdata,
  input  logic             i_dm_ack,
  input  logic [NBITS-1:0] i_dm_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  mem_state_e         state_q, state_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic               unsign_q, unsign_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dm_cmd_t            dm_q, dm_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [NBITS-1:0]   load_q, load_d;

  logic               is_idle;
  logic [1:0]         la_size;
  logic [1:0]         la_addr_lo;
  logic               la_unsign;
  logic [3:0]         be_c;
  logic [NBITS-1:0]   wdata_c;
  logic [NBITS-1:0]   ld_data_c;
  logic               aligned_c;
  logic               start_c;
  logic               misalign_c;

  // In IDLE the aligner looks at the incoming request, afterwards at the captured one.
  assign is_idle    = (state_q == IDLE);
  assign la_size    = is_idle ? i_flg_mem_size  : size_q;
  assign la_addr_lo = is_idle ? i_eff_addr[1:0] : addr_lo_q;
  assign la_unsign  = is_idle ? i_flg_unsign    : unsign_q;

  mem_lane_align u_lane_align (
    .i_size      (la_size),
    .i_addr_lo   (la_addr_lo),
    .i_unsign    (la_unsign),
    .i_st_data   (i_store_data),
    .i_rdata     (i_dm_rdata),
    .o_be_c      (be_c),
    .o_wdata_c   (wdata_c),
    .o_ld_data_c (ld_data_c),
    .o_aligned_c (aligned_c)
  );

  // Gated by reset so the combinational outputs are also quiet while reset is held.
  assign start_c    = i_rst_n & is_idle & i_flg_mem_op & aligned_c;
  assign misalign_c = i_rst_n & is_idle & i_flg_mem_op & ~aligned_c;

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    addr_lo_d = addr_lo_q;
    unsign_d  = unsign_q;
    cnt_d     = cnt_q;
    dm_d      = dm_q;
    req_d     = req_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_d    = load_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          size_d     = i_flg_mem_size;
          addr_lo_d  = i_eff_addr[1:0];
          unsign_d   = i_flg_unsign;
          cnt_d      = '0;
          dm_d.we    = (i_flg_mem_type == MEM_STORE);
          dm_d.addr  = i_eff_addr[NBITS-1:2];
          dm_d.be    = be_c;
          dm_d.wdata = wdata_c;
          req_d      = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (i_dm_ack) begin
          if (dm_q.we == MEM_LOAD) begin
            load_d = ld_data_c;
          end
          dm_d    = '0;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          dm_d    = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      size_q    <= '0;
      addr_lo_q <= '0;
      unsign_q  <= 1'b0;
      cnt_q     <= '0;
      dm_q      <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      load_q    <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      addr_lo_q <= addr_lo_d;
      unsign_q  <= unsign_d;
      cnt_q     <= cnt_d;
      dm_q      <= dm_d;
      req_q     <= req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      load_q    <= load_d;
    end
  end

  assign o_stall     = start_c | (state_q == ACCESS);
  assign o_misalign  = misalign_c;
  assign o_done      = done_q;
  assign o_bus_err   = err_q;
  assign o_load_data = load_q;
  assign o_dm_req    = req_q;
  assign o_dm_we     = dm_q.we;
  assign o_dm_addr   = dm_q.addr;
  assign o_dm_be     = dm_q.be;
  assign o_dm_wdata  = dm_q.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit: a driver queues expected requests
// and responses, a monitor compares them whenever the DUT presents them.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_op;
  logic        mem_type;
  logic [1:0]  mem_size;
  logic        unsign;
  logic [31:0] eff_addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        misalign;
  logic        bus_err;
  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  int tests;
  int fails;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          kind;
    logic [31:0] ld;
  } resp_t;

  req_t  exp_req_q[$];
  resp_t exp_resp_q[$];

  mem_access_unit #(.NBITS(32), .TIMEOUT_CYC(16)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flg_mem_op   (mem_op),
    .i_flg_mem_type (mem_type),
    .i_flg_mem_size (mem_size),
    .i_flg_unsign   (unsign),
    .i_eff_addr     (eff_addr),
    .i_store_data   (store_data),
    .o_stall        (stall),
    .o_load_data    (load_data),
    .o_done         (done),
    .o_misalign     (misalign),
    .o_bus_err      (bus_err),
    .o_dm_req       (dm_req),
    .o_dm_we        (dm_we),
    .o_dm_addr      (dm_addr),
    .o_dm_be        (dm_be),
    .o_dm_wdata     (dm_wdata),
    .i_dm_ack       (dm_ack),
    .i_dm_rdata     (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid low phase, pops expectations when the DUT presents something.
  logic  req_prev;
  req_t  cur_req;
  resp_t cur_resp;
  int    kind_act;

  initial begin
    req_prev = 1'b0;
    cur_req  = '{1'b0, 32'h0, 4'h0, 32'h0};
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        req_prev = 1'b0;
      end else begin
        if (dm_req) begin
          if (!req_prev) begin
            if (exp_req_q.size() == 0) begin
              chk("unexpected_req", 32'(dm_addr), 32'hFFFF_FFFF);
            end else begin
              cur_req = exp_req_q.pop_front();
            end
          end
          chk("req_we", 32'(dm_we), 32'(cur_req.we));
          chk("req_addr", 32'(dm_addr), cur_req.addr);
          chk("req_be", 32'(dm_be), 32'(cur_req.be));
          if (cur_req.we) chk("req_wdata", dm_wdata, cur_req.wdata);
        end
        req_prev = dm_req;
        if (done | misalign | bus_err) begin
          kind_act = done ? 0 : (misalign ? 1 : 2);
          if (exp_resp_q.size() == 0) begin
            chk("unexpected_resp", 32'(kind_act), 32'hFFFF_FFFF);
          end else begin
            cur_resp = exp_resp_q.pop_front();
            chk("resp_kind", 32'(kind_act), 32'(cur_resp.kind));
            if (cur_resp.kind == 0) chk("load_data", load_data, cur_resp.ld);
          end
        end
      end
    end
  end

  // Present one op at the current negedge and run it to its response.
  // kind: 0 done, 1 misalign, 2 bus error.
  task automatic do_op(input string name, input logic typ, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data,
                       input int ack_wait, input logic [31:0] rdata, input int kind,
                       input logic [31:0] exp_ld, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input int exp_stalls, input bit hold);
    int  stalls = 0;
    int  waits  = 0;
    bit  fin    = 1'b0;
    if (kind != 1) exp_req_q.push_back('{typ, addr >> 2, exp_be, exp_wdata});
    exp_resp_q.push_back('{kind, exp_ld});
    mem_op     = 1'b1;
    mem_type   = typ;
    mem_size   = sz;
    unsign     = uns;
    eff_addr   = addr;
    store_data = data;
    for (int i = 0; i < 60 && !fin; i++) begin
      #1;
      dm_ack = 1'b0;
      if (done | misalign | bus_err) begin
        fin = 1'b1;
        if (!bus_err) chk({name, "_stall_at_end"}, 32'(stall), 32'h0);
      end else begin
        if (stall) stalls++;
        if (dm_req) begin
          if (waits == ack_wait) begin
            dm_ack   = 1'b1;
            dm_rdata = rdata;
          end else begin
            waits++;
          end
        end
        @(negedge clk);
      end
    end
    if (!fin) chk({name, "_no_response"}, 32'h0, 32'h1);
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    #2;
    if (!hold) mem_op = 1'b0;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    mem_op     = 1'b0;
    mem_type   = 1'b0;
    mem_size   = 2'b00;
    unsign     = 1'b0;
    eff_addr   = '0;
    store_data = '0;
    dm_ack     = 1'b0;
    dm_rdata   = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(dm_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_be", 32'(dm_be), 32'h0);
    chk("rst_addr", 32'(dm_addr), 32'h0);
    chk("rst_wdata", dm_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //    name      typ   sz     uns  addr          data          wait rdata         kind ld            be       wdata         stalls hold
    do_op("lw",     1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        0,  32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        2,  1'b0); @(negedge clk);
    do_op("lb",     1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        0,  32'h8000_0000, 0, 32'hFFFF_FF80, 4'b1000, 32'h0,        2,  1'b0); @(negedge clk);
    do_op("lbu",    1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        0,  32'h8000_0000, 0, 32'h0000_0080, 4'b1000, 32'h0,        2,  1'b0); @(negedge clk);
    do_op("sh",     1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 3, 32'h0,        0, 32'h0000_0080, 4'b1100, 32'hABCD_ABCD, 5,  1'b0); @(negedge clk);
    do_op("lh",     1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,        1,  32'h8001_0000, 0, 32'hFFFF_8001, 4'b1100, 32'h0,        3,  1'b0); @(negedge clk);
    do_op("lhu",    1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,        0,  32'h1234_F00D, 0, 32'h0000_F00D, 4'b0011, 32'h0,        2,  1'b0); @(negedge clk);
    do_op("sb",     1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 0, 32'h0,        0, 32'h0000_F00D, 4'b0010, 32'hA5A5_A5A5, 2,  1'b0); @(negedge clk);
    do_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        0,  32'h0,         1, 32'h0,         4'b0000, 32'h0,        0,  1'b0); @(negedge clk);
    do_op("lh_mis", 1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0,        0,  32'h0,         1, 32'h0,         4'b0000, 32'h0,        0,  1'b0); @(negedge clk);
    do_op("sh_mis", 1'b1, 2'b01, 1'b0, 32'h0000_0201, 32'h0,        0,  32'h0,         1, 32'h0,         4'b0000, 32'h0,        0,  1'b0); @(negedge clk);
    do_op("lw_sz3", 1'b0, 2'b11, 1'b0, 32'h0000_0300, 32'h0,        0,  32'h0BAD_F00D, 0, 32'h0BAD_F00D, 4'b1111, 32'h0,        2,  1'b0); @(negedge clk);
    do_op("ack_lim", 1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0,       15, 32'h0102_0304, 0, 32'h0102_0304, 4'b1111, 32'h0,        17, 1'b0); @(negedge clk);
    do_op("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,       99, 32'h0,         2, 32'h0,         4'b1111, 32'h0,        17, 1'b0); @(negedge clk);
    #1;
    chk("load_after_timeout", load_data, 32'h0102_0304);
    @(negedge clk);
    do_op("b2b_lw", 1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0,        0,  32'h1122_3344, 0, 32'h1122_3344, 4'b1111, 32'h0,        2,  1'b1); @(negedge clk);
    do_op("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h0000_010C, 32'hCAFE_F00D, 0, 32'h0,        0, 32'h1122_3344, 4'b1111, 32'hCAFE_F00D, 2,  1'b0); @(negedge clk);

    // Reset in the middle of an access: request and stall drop at once, no completion.
    exp_req_q.push_back('{1'b0, 32'h0000_0041, 4'b1111, 32'h0});
    mem_op   = 1'b1;
    mem_type = 1'b0;
    mem_size = 2'b10;
    unsign   = 1'b0;
    eff_addr = 32'h0000_0104;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("pre_rst_req", 32'(dm_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dm_req), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    mem_op = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_load", load_data, 32'h0);
    @(negedge clk);
    do_op("lw_post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0110, 32'h0,   0,  32'h55AA_55AA, 0, 32'h55AA_55AA, 4'b1111, 32'h0,        2,  1'b0);

    repeat (3) @(negedge clk);
    #3;
    chk("req_queue_empty", 32'(exp_req_q.size()), 32'h0);
    chk("resp_queue_empty", 32'(exp_resp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
